prt_lb_init: RTL and testbench
==============================

# prt_lb_init

Local bus initiator. Converts single-cycle host access strobes into level-held `wr`/`rd` transactions on a `prt_dp_lb_if` link. The link's far end is the `prt_lb_mux` upstream port, which edge-detects and routes those transactions. The block sits between the policy-processor/host register port and the mux. It returns read data or a timeout error to the host with a single-cycle acknowledge.

## Interface
Parameters:
- `P_HOLD`, 2: cycles `wr` is held high for a write (min 1).
- `P_GAP`, 2: idle cycles with `wr`=`rd`=0 after every transaction (min 2), so the far-end edge detector re-arms.
- `P_VLD_MASK`, 2: cycles after `rd` rises during which `vld` is ignored, masking stale registered `vld`.
- `P_TIMEOUT`, 64: maximum read wait in cycles, counted from `rd` rising; must be greater than `P_VLD_MASK`.

Ports:
- `CLK_IN`, in, 1: clock; the single clock domain.
- `RST_IN`, in, 1: asynchronous, active-high reset.
- `HOST_ADR_IN`, in, 22: access address; bits [21:16] are the port select, bits [15:0] the register address.
- `HOST_DAT_IN`, in, 32: write data.
- `HOST_WR_IN`, in, 1: write request strobe, one cycle.
- `HOST_RD_IN`, in, 1: read request strobe, one cycle.
- `HOST_BUSY_OUT`, out, 1: transaction in progress; requests are ignored while high.
- `HOST_DAT_OUT`, out, 32: read data, valid with `HOST_ACK_OUT` on reads.
- `HOST_ACK_OUT`, out, 1: transaction complete, one-cycle pulse.
- `HOST_ERR_OUT`, out, 1: read timeout, one-cycle pulse coincident with `HOST_ACK_OUT`.
- `LB_IF`, `prt_dp_lb_if.lb_out`: drives `adr`[21:0], `din`[31:0] (write data), `wr` and `rd`; receives `dout`[31:0] (read data) and `vld`.

## Operation
State machine with states IDLE, WR, RD and GAP.
- **IDLE**
  - `HOST_WR_IN` → latch address and data, go to WR.
  - `HOST_RD_IN` → latch address, go to RD.
  - Both strobes in the same cycle → write wins; the read is dropped.
- **WR**
  - `LB_IF.wr`=1 for exactly `P_HOLD` cycles, then go to GAP.
  - Pulse `HOST_ACK_OUT` on the first GAP cycle.
  - No `vld` is expected for writes.
- **RD**
  - `LB_IF.rd`=1. Counter `c` runs from 0 on the first RD cycle.
  - `vld` is sampled only when `c` ≥ `P_VLD_MASK`.
  - First qualifying `vld`=1 → capture `dout` into `HOST_DAT_OUT`, go to GAP, pulse ACK.
  - `c` = `P_TIMEOUT`-1 without qualifying `vld` → go to GAP, ACK=1, ERR=1, `HOST_DAT_OUT`=0.
  - `vld` on the timeout cycle itself counts as success, not error.
- **GAP**
  - `wr`=`rd`=0 for `P_GAP` cycles, then go to IDLE.
- `LB_IF.adr` and `LB_IF.din` hold the latched values from acceptance until the next accepted request; they do not return to 0 in GAP.
- `HOST_DAT_OUT` holds its value until the next read completes.
- Reset mid-transaction: all outputs drop to reset values immediately; state goes to IDLE; no ACK is issued. The far end sees a `wr`/`rd` falling edge only.

## Timing
- Reset values: state IDLE; `BUSY`, `ACK`, `ERR`, `wr` and `rd` = 0; `adr`, `din` and `HOST_DAT_OUT` = 0.
- All outputs are registered; there are no combinational host-to-LB paths.
- Request sampled in cycle 0:
  - `BUSY`=1 from cycle 1.
  - `wr` or `rd`, `adr` and `din` valid from cycle 1.
- Write: `wr` high in cycles 1..`P_HOLD`; ACK in cycle `P_HOLD`+1; `BUSY` low from cycle `P_HOLD`+`P_GAP`+1.
- Read: qualifying `vld` in cycle k → `rd`=0, ACK and data in cycle k+1; `BUSY` low from cycle k+1+`P_GAP`.
- Minimum read latency (request to ACK) is `P_VLD_MASK`+2 cycles.
- A new request is accepted in the first cycle with `BUSY`=0. Back-to-back throughput for writes is one per `P_HOLD`+`P_GAP`+1 cycles.
- Timeout counter width is `$clog2(P_TIMEOUT)`; it saturates and never wraps.

## Structure
- Shared package `prt_lb_pkg`:
  - state enum `lb_init_sta_t` (IDLE, WR, RD, GAP);
  - local bus widths: address 22, data 32, port-select field [21:16];
  - timeout data constant (32'h0).
- The mux can later import the same width constants from this package.
- No sub-module: the block is one FSM with a shared hold/gap/timeout counter.

## Test plan
- Write 0x01_0004 ← 0x1234_5678 (defaults) → `wr` high cycles 1–2 with adr=0x010004, din=0x12345678; ACK cycle 3; `BUSY` low cycle 5.
- Read 0x02_0010 with responder `vld`=1, `dout`=0xCAFEF00D at cycle 4 → `rd`=0 and ACK at cycle 5, `HOST_DAT_OUT`=0xCAFEF00D, ERR=0.
- Read with `vld` held 1 from cycle 1 (stale) → `vld` ignored in cycles 1–2, accepted at cycle 3, ACK at cycle 4.
- Read with no responder (`P_TIMEOUT`=64) → `rd` high cycles 1–64; ACK and ERR at cycle 65; `HOST_DAT_OUT`=0.
- `HOST_WR_IN` and `HOST_RD_IN` asserted together, then `HOST_RD_IN` while `BUSY` → exactly one write; no `rd` edge ever on `LB_IF`.
- `RST_IN` pulsed at cycle 2 of a read → `rd` and `BUSY` 0 immediately, no ACK; a following write completes normally.

Source files
------------

// File: rtl/prt_lb_pkg.sv
// Shared local bus definitions for the prt local bus initiator and mux.
package prt_lb_pkg;

  // Local bus field widths.
  localparam int LB_ADR_W    = 22;
  localparam int LB_DAT_W    = 32;

  // Port-select field position inside the local bus address.
  localparam int LB_PSEL_MSB = 21;
  localparam int LB_PSEL_LSB = 16;

  // Read data returned to the host when a read times out.
  localparam logic [LB_DAT_W-1:0] LB_TIMEOUT_DAT = 32'h0;

  // Initiator transaction states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    GAP  = 2'd3
  } lb_init_sta_t;

endpackage

// File: rtl/prt_dp_lb_if.sv
// Point-to-point local bus link between an initiator and the mux upstream port.
interface prt_dp_lb_if;
  import prt_lb_pkg::*;

  logic [LB_ADR_W-1:0] adr;
  logic [LB_DAT_W-1:0] din;
  logic                wr;
  logic                rd;
  logic [LB_DAT_W-1:0] dout;
  logic                vld;

  modport lb_out (output adr, din, wr, rd, input dout, vld);
  modport lb_in  (input adr, din, wr, rd, output dout, vld);

endinterface

// File: rtl/prt_lb_init.sv
// Local bus initiator: turns one-cycle host strobes into level-held wr/rd
// transactions, enforces an idle gap so the far-end edge detector re-arms,
// and returns read data or a timeout error with a one-cycle acknowledge.
module prt_lb_init
  import prt_lb_pkg::*;
#(
  parameter int P_HOLD     = 2,
  parameter int P_GAP      = 2,
  parameter int P_VLD_MASK = 2,
  parameter int P_TIMEOUT  = 64
) (
  input  logic                CLK_IN,
  input  logic                RST_IN,
  input  logic [LB_ADR_W-1:0] HOST_ADR_IN,
  input  logic [LB_DAT_W-1:0] HOST_DAT_IN,
  input  logic                HOST_WR_IN,
  input  logic                HOST_RD_IN,
  output logic                HOST_BUSY_OUT,
  output logic [LB_DAT_W-1:0] HOST_DAT_OUT,
  output logic                HOST_ACK_OUT,
  output logic                HOST_ERR_OUT,
  prt_dp_lb_if.lb_out         LB_IF
);

  // One counter is shared by the hold, read-wait and gap phases; it must be
  // wide enough for the longest of them and never narrower than one bit.
  localparam int TW  = $clog2(P_TIMEOUT);
  localparam int HW  = $clog2(P_HOLD);
  localparam int GW  = $clog2(P_GAP);
  localparam int CW0 = (TW > HW) ? TW : HW;
  localparam int CW1 = (CW0 > GW) ? CW0 : GW;
  localparam int CW  = (CW1 < 1) ? 1 : CW1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(P_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(P_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(P_TIMEOUT - 1);
  localparam logic [CW-1:0] VLD_FIRST = CW'(P_VLD_MASK);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  lb_init_sta_t        state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [LB_ADR_W-1:0] adr_q, adr_nx;
  logic [LB_DAT_W-1:0] din_q, din_nx;
  logic [LB_DAT_W-1:0] dat_q, dat_nx;
  logic                ack_q, ack_nx;
  logic                err_q, err_nx;
  logic                wr_q, rd_q, busy_q;

  // Next-state and next-output logic; outputs are derived from the next state
  // so every host and link output leaves this block straight from a flop.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    adr_nx   = adr_q;
    din_nx   = din_q;
    dat_nx   = dat_q;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (HOST_WR_IN) begin
          adr_nx   = HOST_ADR_IN;
          din_nx   = HOST_DAT_IN;
          cnt_nx   = '0;
          state_nx = WR;
        end else if (HOST_RD_IN) begin
          adr_nx   = HOST_ADR_IN;
          cnt_nx   = '0;
          state_nx = RD;
        end
      end
      WR: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx   = '0;
          ack_nx   = 1'b1;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RD: begin
        if ((cnt >= VLD_FIRST) && LB_IF.vld) begin
          dat_nx   = LB_IF.dout;
          cnt_nx   = '0;
          ack_nx   = 1'b1;
          state_nx = GAP;
        end else if (cnt == TO_LAST) begin
          dat_nx   = LB_TIMEOUT_DAT;
          cnt_nx   = '0;
          ack_nx   = 1'b1;
          err_nx   = 1'b1;
          state_nx = GAP;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops everything at once so
  // the far end only ever sees a falling wr/rd edge on an aborted transaction.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state  <= IDLE;
      cnt    <= '0;
      adr_q  <= '0;
      din_q  <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      adr_q  <= adr_nx;
      din_q  <= din_nx;
      dat_q  <= dat_nx;
      ack_q  <= ack_nx;
      err_q  <= err_nx;
      wr_q   <= (state_nx == WR);
      rd_q   <= (state_nx == RD);
      busy_q <= (state_nx != IDLE);
    end
  end

  assign HOST_BUSY_OUT = busy_q;
  assign HOST_DAT_OUT  = dat_q;
  assign HOST_ACK_OUT  = ack_q;
  assign HOST_ERR_OUT  = err_q;
  assign LB_IF.adr     = adr_q;
  assign LB_IF.din     = din_q;
  assign LB_IF.wr      = wr_q;
  assign LB_IF.rd      = rd_q;

endmodule

// File: tb/tb_prt_lb_init.sv
// Directed bench for prt_lb_init with a scoreboard of expected acknowledges.
module tb_prt_lb_init;
  import prt_lb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] host_adr;
  logic [31:0] host_dat;
  logic        host_wr;
  logic        host_rd;
  logic        busy;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  prt_dp_lb_if lb ();

  prt_lb_init #(
    .P_HOLD    (2),
    .P_GAP     (2),
    .P_VLD_MASK(2),
    .P_TIMEOUT (64)
  ) dut (
    .CLK_IN       (clk),
    .RST_IN       (rst),
    .HOST_ADR_IN  (host_adr),
    .HOST_DAT_IN  (host_dat),
    .HOST_WR_IN   (host_wr),
    .HOST_RD_IN   (host_rd),
    .HOST_BUSY_OUT(busy),
    .HOST_DAT_OUT (rdat),
    .HOST_ACK_OUT (ack),
    .HOST_ERR_OUT (err),
    .LB_IF        (lb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_dat;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_io(input string tag, input logic b, input logic w, input logic r, input logic a);
    check_output({tag, "_busy"}, {31'b0, busy},   {31'b0, b});
    check_output({tag, "_wr"},   {31'b0, lb.wr},  {31'b0, w});
    check_output({tag, "_rd"},   {31'b0, lb.rd},  {31'b0, r});
    check_output({tag, "_ack"},  {31'b0, ack},    {31'b0, a});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a write in the current cycle (cycle 0); returns in cycle 1.
  task automatic apply_stimulus_wr(input logic [21:0] adr, input logic [31:0] dat);
    host_adr = adr;
    host_dat = dat;
    host_wr  = 1'b1;
    exp_q.push_back('{model_dat, 1'b0});
    step();
    host_wr  = 1'b0;
  endtask

  // Issue a read in the current cycle (cycle 0); returns in cycle 1.
  task automatic apply_stimulus_rd(input logic [21:0] adr, input logic [31:0] dat,
                                   input logic e, input logic expect_ack);
    host_adr = adr;
    host_rd  = 1'b1;
    if (expect_ack) begin
      exp_q.push_back('{dat, e});
      model_dat = dat;
    end
    step();
    host_rd  = 1'b0;
  endtask

  // Every acknowledge pops the oldest expectation and checks data and error.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL unexpected_ack: observed ack=1 expected no ack");
      end else begin
        e = exp_q.pop_front();
        check_output("sb_dat", rdat, e.dat);
        check_output("sb_err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish by 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd_hi;
    int wr_hi;
    rst       = 1'b1;
    host_adr  = '0;
    host_dat  = '0;
    host_wr   = 1'b0;
    host_rd   = 1'b0;
    lb.vld    = 1'b0;
    lb.dout   = '0;
    model_dat = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_io("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("reset_err", {31'b0, err}, 32'h0);
    check_output("reset_adr", {10'b0, lb.adr}, 32'h0);
    check_output("reset_din", lb.din, 32'h0);
    check_output("reset_dat", rdat, 32'h0);
    rst = 1'b0;
    step();

    // Write 0x010004 <- 0x12345678
    apply_stimulus_wr(22'h01_0004, 32'h1234_5678);
    check_io("wr_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("wr_adr", {10'b0, lb.adr}, 32'h0001_0004);
    check_output("wr_din", lb.din, 32'h1234_5678);
    step();
    check_io("wr_c2", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_io("wr_c3", 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check_io("wr_c4", 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("wr_gap_adr", {10'b0, lb.adr}, 32'h0001_0004);
    step();
    check_io("wr_c5", 1'b0, 1'b0, 1'b0, 1'b0);

    // Read 0x020010, responder vld at cycle 4
    apply_stimulus_rd(22'h02_0010, 32'hCAFE_F00D, 1'b0, 1'b1);
    check_io("rd_c1", 1'b1, 1'b0, 1'b1, 1'b0);
    check_output("rd_adr", {10'b0, lb.adr}, 32'h0002_0010);
    step();
    check_io("rd_c2", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_io("rd_c3", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_io("rd_c4", 1'b1, 1'b0, 1'b1, 1'b0);
    lb.vld  = 1'b1;
    lb.dout = 32'hCAFE_F00D;
    step();
    lb.vld  = 1'b0;
    lb.dout = 32'h0;
    check_io("rd_c5", 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("rd_dat", rdat, 32'hCAFE_F00D);
    check_output("rd_err", {31'b0, err}, 32'h0);
    step();
    check_io("rd_c6", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_io("rd_c7", 1'b0, 1'b0, 1'b0, 1'b0);

    // Read with stale vld held from cycle 1
    apply_stimulus_rd(22'h02_0014, 32'hA5A5_5A5A, 1'b0, 1'b1);
    lb.vld  = 1'b1;
    lb.dout = 32'hA5A5_5A5A;
    check_io("stale_c1", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_io("stale_c2", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_io("stale_c3", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    lb.vld  = 1'b0;
    lb.dout = 32'h0;
    check_io("stale_c4", 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("stale_dat", rdat, 32'hA5A5_5A5A);
    step();
    step();
    check_io("stale_c6", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset pulsed at cycle 2 of a read
    apply_stimulus_rd(22'h04_0008, 32'h0, 1'b0, 1'b0);
    check_io("rst_c1", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    model_dat = 32'h0;
    check_io("rst_now", 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("rst_dat", rdat, 32'h0);
    check_output("rst_adr", {10'b0, lb.adr}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check_io("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus_wr(22'h05_0000, 32'h0BAD_CAFE);
    check_io("rstwr_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("rstwr_din", lb.din, 32'h0BAD_CAFE);
    step();
    step();
    check_io("rstwr_c3", 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    step();
    check_io("rstwr_c5", 1'b0, 1'b0, 1'b0, 1'b0);

    // Write and read strobes together, then a read while busy
    host_rd = 1'b1;
    apply_stimulus_wr(22'h03_0020, 32'hDEAD_BEEF);
    check_output("both_adr", {10'b0, lb.adr}, 32'h0003_0020);
    check_output("both_din", lb.din, 32'hDEAD_BEEF);
    host_rd = 1'b1;
    rd_hi = 0;
    wr_hi = 0;
    for (int c = 1; c <= 6; c++) begin
      if (lb.rd) rd_hi++;
      if (lb.wr) wr_hi++;
      if (c == 5) check_output("both_busy_c5", {31'b0, busy}, 32'h0);
      step();
      if (c == 1) host_rd = 1'b0;
    end
    check_output("both_rd_cycles", rd_hi, 32'd0);
    check_output("both_wr_cycles", wr_hi, 32'd2);

    // Read with no responder times out
    apply_stimulus_rd(22'h06_0000, LB_TIMEOUT_DAT, 1'b1, 1'b1);
    for (int c = 1; c <= 64; c++) begin
      check_output("to_rd", {31'b0, lb.rd}, 32'h1);
      check_output("to_ack", {31'b0, ack}, 32'h0);
      step();
    end
    check_io("to_c65", 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("to_err", {31'b0, err}, 32'h1);
    check_output("to_dat", rdat, 32'h0);
    step();
    check_output("to_err_pulse", {31'b0, err}, 32'h0);
    step();
    check_io("to_c67", 1'b0, 1'b0, 1'b0, 1'b0);

    step();
    check_output("pending_acks", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
